mem_wb_unit_206: RTL and testbench

Write-back end of the pipeline: the MEM/WB pipeline register plus the write-back datapath that drives the register-file write port of `IDUnit_206` (`busW`, `Rw_Wr`, `RegWr_Wr`, `OverFlow_Wr`, `Jal_Wr`), which are currently tied off in `PipeLine_CPU`. It captures the MEM-stage result each cycle, honours stall/flush, and extracts and extends sub-word loads. It selects ALU result, load data or link address onto `busW`. An optional retire counter counts instructions leaving WB.

---
 rtl/mem_wb_unit_206_pkg.sv | 28 ++
 rtl/load_align_206.sv | 26 ++
 rtl/mem_wb_unit_206.sv | 73 +++++++
 tb/tb_mem_wb_unit_206.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/mem_wb_unit_206_pkg.sv
// mem_wb_unit_206_pkg: load-type encodings and link register shared with decode
package mem_wb_unit_206_pkg;

    typedef enum logic [2:0] {
        LD_W  = 3'd0,
        LD_B  = 3'd1,
        LD_BU = 3'd2,
        LD_H  = 3'd3,
        LD_HU = 3'd4
    } load_type_e;

    localparam logic [4:0] LINK_REG_DEFAULT = 5'd31;

    // Contents of the MEM/WB pipeline register
    typedef struct packed {
        logic        valid;
        logic [31:0] alu;
        logic [31:0] mem;
        logic [31:0] pc;
        logic [4:0]  rw;
        logic        reg_wr;
        logic        mem_to_reg;
        logic        jal;
        logic        overflow;
        logic [2:0]  load_type;
    } wb_reg_t;

endpackage

// File: rtl/load_align_206.sv
// load_align_206: picks a byte/halfword out of a big-endian word and extends it
module load_align_206
    import mem_wb_unit_206_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  a,
    input  logic [2:0]  load_type,
    output logic [31:0] value
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Byte 0 sits in the top lane; halfwords ignore a[0]
    always_comb begin
        byte_sel = a == 2'd0 ? word[31:24] :
                   a == 2'd1 ? word[23:16] :
                   a == 2'd2 ? word[15:8]  : word[7:0];
        half_sel = a[1] ? word[15:0] : word[31:16];
        value    = load_type == LD_B  ? {{24{byte_sel[7]}}, byte_sel} :
                   load_type == LD_BU ? {24'd0, byte_sel} :
                   load_type == LD_H  ? {{16{half_sel[15]}}, half_sel} :
                   load_type == LD_HU ? {16'd0, half_sel} : word;
    end

endmodule

// File: rtl/mem_wb_unit_206.sv
// mem_wb_unit_206: MEM/WB register and write-back mux; WB_RETIRE_CNT_EN adds a retire counter
module mem_wb_unit_206
    import mem_wb_unit_206_pkg::*;
#(
    parameter logic [31:0] LINK_OFFSET = 32'd4,
    parameter logic [4:0]  LINK_REG    = LINK_REG_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        flush,
    input  logic [31:0] ALU_Result_IN,
    input  logic [31:0] Mem_Dout_IN,
    input  logic [31:0] PC_Addr_IN,
    input  logic [4:0]  Rw_IN,
    input  logic        RegWr_IN,
    input  logic        MemtoReg_IN,
    input  logic        Jal_IN,
    input  logic        OverFlow_IN,
    input  logic [2:0]  Load_Type_IN,
    output logic [31:0] busW,
    output logic [4:0]  Rw_Wr,
    output logic        RegWr_Wr,
    output logic        OverFlow_Wr,
    output logic        Jal_Wr,
    output logic [31:0] Retired_Cnt
);

    wb_reg_t     r;
    logic [31:0] load_value;

    // Pipeline register: stall holds, flush loads an all-zero bubble
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r <= '0;
        else if (!stall)
            r <= flush ? '0 : {1'b1, ALU_Result_IN, Mem_Dout_IN, PC_Addr_IN, Rw_IN,
                               RegWr_IN, MemtoReg_IN, Jal_IN, OverFlow_IN, Load_Type_IN};
    end

    load_align_206 u_align (
        .word      (r.mem),
        .a         (r.alu[1:0]),
        .load_type (r.load_type),
        .value     (load_value)
    );

    // Write-back outputs depend only on registered state
    always_comb begin
        busW        = r.jal ? r.pc + LINK_OFFSET : r.mem_to_reg ? load_value : r.alu;
        Rw_Wr       = r.jal ? LINK_REG : r.rw;
        RegWr_Wr    = r.valid & (r.reg_wr | r.jal) & (Rw_Wr != 5'd0);
        OverFlow_Wr = r.valid & r.overflow;
        Jal_Wr      = r.valid & r.jal;
    end

`ifdef WB_RETIRE_CNT_EN
    logic [31:0] cnt;

    // An instruction retires when it leaves WB un-stalled
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (!stall && r.valid)
            cnt <= cnt + 32'd1;
    end

    assign Retired_Cnt = cnt;
`else
    assign Retired_Cnt = '0;
`endif

endmodule

// File: tb/tb_mem_wb_unit_206.sv
// tb_mem_wb_unit_206: directed scoreboard bench for the write-back unit
module tb_mem_wb_unit_206;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic [31:0] alu_in = '0;
    logic [31:0] mem_in = '0;
    logic [31:0] pc_in = '0;
    logic [4:0]  rw_in = '0;
    logic        regwr_in = 1'b0;
    logic        m2r_in = 1'b0;
    logic        jal_in = 1'b0;
    logic        ovf_in = 1'b0;
    logic [2:0]  lt_in = '0;
    logic [31:0] busW;
    logic [4:0]  Rw_Wr;
    logic        RegWr_Wr;
    logic        OverFlow_Wr;
    logic        Jal_Wr;
    logic [31:0] Retired_Cnt;

    int total = 0;
    int bad = 0;

    typedef struct {
        logic        chk_data;
        logic [31:0] bus;
        logic [4:0]  rw;
        logic        regwr;
        logic        ovf;
        logic        jal;
        logic [31:0] cnt;
    } exp_t;

    exp_t sb[$];

    logic        m_valid = 1'b0;
    logic [31:0] m_alu = '0, m_mem = '0, m_pc = '0, m_cnt = '0;
    logic [4:0]  m_rw = '0;
    logic        m_regwr = 1'b0, m_m2r = 1'b0, m_jal = 1'b0, m_ovf = 1'b0;
    logic [2:0]  m_lt = '0;

    always #5 clk = ~clk;

    mem_wb_unit_206 dut (
        .clk           (clk),
        .rst           (rst),
        .stall         (stall),
        .flush         (flush),
        .ALU_Result_IN (alu_in),
        .Mem_Dout_IN   (mem_in),
        .PC_Addr_IN    (pc_in),
        .Rw_IN         (rw_in),
        .RegWr_IN      (regwr_in),
        .MemtoReg_IN   (m2r_in),
        .Jal_IN        (jal_in),
        .OverFlow_IN   (ovf_in),
        .Load_Type_IN  (lt_in),
        .busW          (busW),
        .Rw_Wr         (Rw_Wr),
        .RegWr_Wr      (RegWr_Wr),
        .OverFlow_Wr   (OverFlow_Wr),
        .Jal_Wr        (Jal_Wr),
        .Retired_Cnt   (Retired_Cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_load(input logic [31:0] w, input logic [1:0] a,
                                               input logic [2:0] lt);
        logic [31:0] sh;
        logic [15:0] h;
        sh = w << (8 * a);
        h  = a[1] ? w[15:0] : w[31:16];
        case (lt)
            3'd1:    return {{24{sh[31]}}, sh[31:24]};
            3'd2:    return {24'd0, sh[31:24]};
            3'd3:    return {{16{h[15]}}, h};
            3'd4:    return {16'd0, h};
            default: return w;
        endcase
    endfunction

    task automatic step(input logic s, input logic f, input logic [31:0] alu,
                        input logic [31:0] mem, input logic [31:0] pc, input logic [4:0] rw,
                        input logic rwr, input logic m2r, input logic j, input logic o,
                        input logic [2:0] lt, input string tag);
        exp_t e, g;
        @(negedge clk);
        stall = s; flush = f; alu_in = alu; mem_in = mem; pc_in = pc; rw_in = rw;
        regwr_in = rwr; m2r_in = m2r; jal_in = j; ovf_in = o; lt_in = lt;
`ifdef WB_RETIRE_CNT_EN
        if (!s && m_valid) m_cnt = m_cnt + 32'd1;
`endif
        if (!s) begin
            m_valid = !f;
            m_alu = alu; m_mem = mem; m_pc = pc; m_rw = rw; m_lt = lt;
            m_regwr = rwr & !f; m_m2r = m2r & !f; m_jal = j & !f; m_ovf = o & !f;
        end
        e.chk_data = m_valid;
        e.bus   = m_jal ? m_pc + 32'd4 : m_m2r ? model_load(m_mem, m_alu[1:0], m_lt) : m_alu;
        e.rw    = m_jal ? 5'd31 : m_rw;
        e.regwr = m_valid & (m_regwr | m_jal) & (e.rw != 5'd0);
        e.ovf   = m_valid & m_ovf;
        e.jal   = m_valid & m_jal;
        e.cnt   = m_cnt;
        sb.push_back(e);
        @(posedge clk);
        #1;
        g = sb.pop_front();
        if (g.chk_data) begin
            chk({tag, ".busW"}, busW, g.bus);
            chk({tag, ".Rw_Wr"}, {27'd0, Rw_Wr}, {27'd0, g.rw});
        end
        chk({tag, ".RegWr_Wr"}, {31'd0, RegWr_Wr}, {31'd0, g.regwr});
        chk({tag, ".OverFlow_Wr"}, {31'd0, OverFlow_Wr}, {31'd0, g.ovf});
        chk({tag, ".Jal_Wr"}, {31'd0, Jal_Wr}, {31'd0, g.jal});
        chk({tag, ".Retired_Cnt"}, Retired_Cnt, g.cnt);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ".busW"}, busW, 32'd0);
        chk({tag, ".Rw_Wr"}, {27'd0, Rw_Wr}, 32'd0);
        chk({tag, ".ctl"}, {29'd0, RegWr_Wr, OverFlow_Wr, Jal_Wr}, 32'd0);
        chk({tag, ".Retired_Cnt"}, Retired_Cnt, 32'd0);
    endtask

    localparam logic [31:0] W = 32'h80FF_7F01;

    initial begin
        #3 rst = 1'b1;
        #1 chk_zero("reset_async");
        repeat (2) @(posedge clk);
        #1 chk_zero("reset_held");
        @(negedge clk);
        flush = 1'b1;
        rst = 1'b0;
        step(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, "idle_flush");
        chk_zero("idle_zero");
        step(0, 0, 32'h1234_5678, 0, 0, 8, 1, 0, 0, 0, 0, "alu_write");
        step(0, 0, 32'h0000_1000, W, 0, 9, 1, 1, 0, 0, 3'd1, "lb_a0");
        step(0, 0, 32'h0000_1001, W, 0, 9, 1, 1, 0, 0, 3'd2, "lbu_a1");
        step(0, 0, 32'h0000_1002, W, 0, 9, 1, 1, 0, 0, 3'd3, "lh_a2");
        step(0, 0, 32'h0000_1000, W, 0, 9, 1, 1, 0, 0, 3'd4, "lhu_a0");
        step(0, 0, 32'h0000_1003, W, 0, 9, 1, 1, 0, 0, 3'd7, "lw_lt7");
        step(0, 0, 32'h0000_0003, W, 0, 9, 1, 1, 0, 0, 3'd3, "lh_a3");
        step(0, 0, 32'hDEAD_BEEF, 0, 32'h0040_0010, 0, 0, 0, 1, 0, 0, "jal");
        step(0, 0, 32'h0000_0055, 0, 0, 0, 1, 0, 0, 0, 0, "wr_r0");
        step(0, 0, 32'h7FFF_FFFF, 0, 0, 5, 1, 0, 0, 1, 0, "overflow");
        for (int i = 0; i < 3; i++)
            step(1, 1, 32'hCAFE_0000 + i, W, 32'h100, 7, 1, 1, 1, 0, 3'd1, "stall_flush");
        step(0, 1, 32'h1111_1111, W, 0, 3, 1, 0, 0, 1, 0, "flush_bubble");
        for (int i = 0; i < 5; i++)
            step(0, 0, 32'h0000_0100 + i, 0, 0, 5'(10 + i), 1, 0, 0, 0, 0, "retire");
        step(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, "retire_drain");
        step(0, 0, 32'h2222_2222, 0, 0, 12, 1, 0, 0, 0, 0, "pre_rst");
        @(negedge clk);
        stall = 1'b1;
        #2 rst = 1'b1;
        #1 chk_zero("reset_mid_stall");
        @(negedge clk);
        rst = 1'b0;
        stall = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
